// File: rtl/hazard_stall_ctrl.sv
// Load-use and multi-cycle divide hazard control: combinational stall/bubble/strobe outputs, registered Div_Busy/Div_Done.
// A divide request stalls the front end for DIV_CYCLES+1 cycles; a load-use hazard costs one bubble; Exc_Flush overrides both.
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_ReadsRs,
  input  logic       ID_ReadsRt,
  input  logic [4:0] EXE_Dst,
  input  logic       EXE_IsLoad,
  input  logic       EXE_DivReq,
  input  logic       Exc_Flush,
  output logic       IF_Stall,
  output logic       ID_Stall,
  output logic       EXE_Stall,
  output logic       ID_Bubble,
  output logic       EXE_Bubble,
  output logic       Div_Start,
  output logic       Div_Abort,
  output logic       Div_Busy,
  output logic       Div_Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q;
  logic          load_use;
  logic          div_stall;
  logic          active;

  assign load_use = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                    ((ID_ReadsRs && (ID_rs == EXE_Dst)) ||
                     (ID_ReadsRt && (ID_rt == EXE_Dst)));

  // Outputs are gated while reset is asserted so a held request cannot leak through.
  assign active = resetn && !Exc_Flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_stall  = 1'b0;
    Div_Start  = 1'b0;
    Div_Abort  = 1'b0;
    IF_Stall   = 1'b0;
    ID_Stall   = 1'b0;
    EXE_Stall  = 1'b0;
    ID_Bubble  = 1'b0;
    EXE_Bubble = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (EXE_DivReq && active) begin
          Div_Start = 1'b1;
          div_stall = 1'b1;
          state_d   = S_DIV;
          cnt_d     = CW'(DIV_CYCLES - 1);
        end
      end
      S_DIV: begin
        div_stall = 1'b1;
        if (Exc_Flush) begin
          Div_Abort = resetn;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      // The finishing DIV is still in EXE this cycle, so its request is ignored.
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (active) begin
      if (div_stall) begin
        IF_Stall   = 1'b1;
        ID_Stall   = 1'b1;
        EXE_Stall  = 1'b1;
        EXE_Bubble = 1'b1;
      end else if (load_use) begin
        IF_Stall  = 1'b1;
        ID_Stall  = 1'b1;
        ID_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_DIV);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign Div_Busy = busy_q;
  assign Div_Done = done_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with DIV_CYCLES=4; output vector order:
// {IF_Stall, ID_Stall, EXE_Stall, ID_Bubble, EXE_Bubble, Div_Start, Div_Abort, Div_Busy, Div_Done}.
module tb_hazard_stall_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] ID_rs, ID_rt, EXE_Dst;
  logic       ID_ReadsRs, ID_ReadsRt, EXE_IsLoad, EXE_DivReq, Exc_Flush;
  logic       IF_Stall, ID_Stall, EXE_Stall, ID_Bubble, EXE_Bubble;
  logic       Div_Start, Div_Abort, Div_Busy, Div_Done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DIV_CYCLES(DC), .CW(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_ReadsRs (ID_ReadsRs),
    .ID_ReadsRt (ID_ReadsRt),
    .EXE_Dst    (EXE_Dst),
    .EXE_IsLoad (EXE_IsLoad),
    .EXE_DivReq (EXE_DivReq),
    .Exc_Flush  (Exc_Flush),
    .IF_Stall   (IF_Stall),
    .ID_Stall   (ID_Stall),
    .EXE_Stall  (EXE_Stall),
    .ID_Bubble  (ID_Bubble),
    .EXE_Bubble (EXE_Bubble),
    .Div_Start  (Div_Start),
    .Div_Abort  (Div_Abort),
    .Div_Busy   (Div_Busy),
    .Div_Done   (Div_Done)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rdrs;
    logic       rdrt;
    logic       ld;
    logic       dreq;
    logic       fl;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] LU   = 9'b110100000;
  localparam logic [8:0] STRT = 9'b111011000;
  localparam logic [8:0] BUSY = 9'b111010010;
  localparam logic [8:0] DONE = 9'b000000001;
  localparam logic [8:0] ABRT = 9'b000000110;
  localparam logic [8:0] NONE = 9'b000000000;

  vec_t tbl[12];

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {IF_Stall, ID_Stall, EXE_Stall, ID_Bubble, EXE_Bubble,
           Div_Start, Div_Abort, Div_Busy, Div_Done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [8:0] exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic rdrs, input logic rdrt, input logic ld,
                       input logic dreq, input logic fl);
    ID_rs      = rs;
    ID_rt      = rt;
    EXE_Dst    = dst;
    ID_ReadsRs = rdrs;
    ID_ReadsRt = rdrt;
    EXE_IsLoad = ld;
    EXE_DivReq = dreq;
    Exc_Flush  = fl;
  endtask

  task automatic idle_in();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LU};
    tbl[1]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NONE};
    tbl[2]  = '{5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NONE};
    tbl[3]  = '{5'd0,  5'd7,  5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LU};
    tbl[4]  = '{5'd3,  5'd7,  5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NONE};
    tbl[5]  = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE};
    tbl[6]  = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, NONE};
    tbl[7]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NONE};
    tbl[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
    tbl[9]  = '{5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, LU};
    tbl[10] = '{5'd31, 5'd30, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, LU};
    tbl[11] = '{5'd4,  5'd6,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NONE};

    // Reset: outputs quiet even with a divide request held.
    resetn = 1'b0;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #12;
    check("reset_gated", NONE);
    idle_in();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc("after_reset", NONE);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].rdrs, tbl[i].rdrt,
            tbl[i].ld, tbl[i].dreq, tbl[i].fl);
      cyc($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Single division with a concurrent load-use in the request cycle; divide wins.
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("div_T", STRT);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= DC; k++) cyc($sformatf("div_T+%0d", k), BUSY);
    cyc("div_done", DONE);
    idle_in();
    cyc("div_after", NONE);

    // Back-to-back: second DIV arrives right after the first leaves.
    EXE_DivReq = 1'b1;
    cyc("b2b_T", STRT);
    for (int k = 1; k <= DC; k++) cyc($sformatf("b2b_T+%0d", k), BUSY);
    cyc("b2b_done1", DONE);
    cyc("b2b_start2", STRT);
    for (int k = 7; k <= 10; k++) cyc($sformatf("b2b_T+%0d", k), BUSY);
    cyc("b2b_done2", DONE);
    idle_in();
    cyc("b2b_after", NONE);

    // Abort mid-divide.
    EXE_DivReq = 1'b1;
    cyc("abt_T", STRT);
    cyc("abt_T+1", BUSY);
    Exc_Flush = 1'b1;
    cyc("abt_flush", ABRT);
    idle_in();
    for (int k = 3; k <= 7; k++) cyc($sformatf("abt_T+%0d", k), NONE);

    // Async reset during S_DIV, request still asserted.
    EXE_DivReq = 1'b1;
    cyc("ar_T", STRT);
    cyc("ar_T+1", BUSY);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("ar_immediate", NONE);
    @(posedge clk);
    #1;
    EXE_DivReq = 1'b0;
    resetn = 1'b1;
    cyc("ar_released", NONE);
    EXE_DivReq = 1'b1;
    cyc("ar_restart", STRT);
    idle_in();
    Exc_Flush = 1'b1;
    cyc("ar_flush_kill", ABRT);
    Exc_Flush = 1'b0;
    cyc("ar_idle", NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
